// File: rtl/array_refresh_sched.sv
// array_refresh_sched: periodic refresh scheduler and array ownership arbiter.
// A tREFI interval timer produces refresh ticks. Ticks are banked in a credit
// counter of owed refreshes that drains through a start/done handshake with
// the refresh engine. The host is granted the array whenever refresh is not
// urgently owed. An active host grant is never preempted. Urgency only stops
// the next grant from being issued.
// MAX_POSTPONE must lie in 1..7 so that it fits the 3-bit rf_pending port.
module array_refresh_sched #(
  parameter int TREFI_WIDTH  = 16,
  parameter int MAX_POSTPONE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rf_en,
  input  logic [TREFI_WIDTH-1:0] array_tREFI,
  input  logic                   host_req,
  output logic                   host_grant,
  output logic                   rf_start,
  input  logic                   rf_done,
  output logic [2:0]             rf_pending,
  output logic                   rf_urgent,
  output logic                   rf_overflow
);

  localparam logic [2:0] MAX_P = 3'(MAX_POSTPONE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOST     = 2'd1,
    RF_ISSUE = 2'd2,
    RF_WAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TREFI_WIDTH-1:0] timer_q, timer_d;
  logic [TREFI_WIDTH-1:0] timer_eff;
  logic [TREFI_WIDTH-1:0] reload_val;
  logic                   armed_q, armed_d;
  logic                   timer_active;
  logic                   tick;

  logic [2:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic       rf_dec;

  logic host_grant_q, host_grant_d;
  logic rf_start_q, rf_start_d;

  // Interval timer. While disabled, it holds the reload value. armed_q records
  // that the timer has held a loaded value for at least one cycle. Without it,
  // the zero left by reset would fire a tick at once when leaving reset with
  // rf_en already high. With it, the first tick always comes tREFI cycles
  // after the timer starts running.
  always_comb begin
    reload_val   = array_tREFI - TREFI_WIDTH'(1);
    timer_active = rf_en && (array_tREFI != '0);
    timer_eff    = armed_q ? timer_q : reload_val;
    tick         = timer_active && (timer_eff == '0);
    armed_d      = timer_active;
    if (!timer_active || tick) begin
      timer_d = reload_val;
    end else begin
      timer_d = timer_eff - TREFI_WIDTH'(1);
    end
  end

  // Owed-refresh credits. A tick adds one credit. A done accepted in RF_WAIT
  // removes one. If both happen in the same cycle they cancel. A tick that
  // arrives at saturation is lost and is recorded in the sticky overflow flag.
  always_comb begin
    rf_dec     = (state_q == RF_WAIT) && rf_done;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (tick && !rf_dec) begin
      if (pending_q == MAX_P) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (!tick && rf_dec && (pending_q != 3'd0)) begin
      pending_d = pending_q - 3'd1;
    end
  end

  // Ownership FSM, next state. The order of the checks in IDLE sets the
  // priority: urgent refresh, then host, then non-urgent refresh. Every
  // ownership ends by passing through IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rf_urgent) begin
          state_d = RF_ISSUE;
        end else if (host_req) begin
          state_d = HOST;
        end else if (pending_q != 3'd0) begin
          state_d = RF_ISSUE;
        end
      end
      HOST: begin
        if (!host_req) begin
          state_d = IDLE;
        end
      end
      RF_ISSUE: begin
        state_d = RF_WAIT;
      end
      RF_WAIT: begin
        if (rf_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The outputs are decoded from the next state and then registered, so they
  // change on the same edge as the state and never glitch.
  always_comb begin
    host_grant_d = (state_d == HOST);
    rf_start_d   = (state_d == RF_ISSUE);
  end

  // State registers. Reset clears all of them at once, without waiting for a
  // clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      armed_q      <= 1'b0;
      pending_q    <= 3'd0;
      overflow_q   <= 1'b0;
      host_grant_q <= 1'b0;
      rf_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      host_grant_q <= host_grant_d;
      rf_start_q   <= rf_start_d;
    end
  end

  assign host_grant  = host_grant_q;
  assign rf_start    = rf_start_q;
  assign rf_pending  = pending_q;
  assign rf_urgent   = (pending_q == MAX_P);
  assign rf_overflow = overflow_q;

endmodule

// File: doc/array_refresh_sched.md
Name: array_refresh_sched

Overview:
- Schedules periodic refresh of the memory array and arbitrates array ownership between the host access path and the refresh engine.
- Holds a tREFI interval timer and a postponed-refresh credit counter.
- Issues a one-cycle start pulse to the refresh engine and waits for its done pulse.
- Grants the array to the host whenever refresh is not owed urgently.

Parameters:
- TREFI_WIDTH, 16, width of the refresh interval config and timer.
- MAX_POSTPONE, 4, maximum owed refreshes before refresh becomes urgent; must be 1..7.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rf_en  input  1  refresh scheduling enable (quasi-static)
- array_tREFI  input  TREFI_WIDTH  refresh interval in clk cycles; 0 = timer disabled
- host_req  input  1  host requests array ownership (level, held for the whole access)
- host_grant  output  1  host owns the array
- rf_start  output  1  one-cycle pulse to the refresh engine
- rf_done  input  1  one-cycle pulse from the refresh engine at end of refresh
- rf_pending  output  3  owed refreshes, 0..MAX_POSTPONE
- rf_urgent  output  1  rf_pending == MAX_POSTPONE
- rf_overflow  output  1  sticky flag: a tick arrived while rf_pending == MAX_POSTPONE

Behaviour:
- Reset values: host_grant=0, rf_start=0, rf_pending=0, rf_overflow=0, FSM=IDLE, timer=0.
- rf_urgent is combinational from rf_pending.
- Timer:
  - If rf_en=0 or array_tREFI=0, the timer is loaded with array_tREFI-1 and produces no tick.
  - Otherwise it decrements each cycle. At 0 it generates a tick and reloads array_tREFI-1.
  - First tick occurs array_tREFI cycles after rf_en rises.
- Pending counter, updated each cycle:
  - +1 on tick.
  - -1 on rf_done accepted in RF_WAIT.
  - Tick and decrement in the same cycle: no change.
  - Tick at MAX_POSTPONE without decrement: saturate and set rf_overflow (cleared only by reset).
  - Clearing rf_en does not clear rf_pending; owed refreshes still drain.
- FSM states: IDLE, HOST, RF_ISSUE, RF_WAIT. All outputs are registered from state.
  - IDLE:
    - rf_urgent=1 -> RF_ISSUE.
    - Else host_req=1 -> HOST.
    - Else rf_pending!=0 -> RF_ISSUE.
    - Else stay in IDLE.
    - Urgent refresh beats host; host beats non-urgent refresh.
  - HOST:
    - host_grant=1.
    - host_req=0 -> IDLE; host_grant drops the same edge.
    - Urgency never preempts an active grant; it only blocks the next grant.
  - RF_ISSUE:
    - rf_start=1 for exactly one cycle -> RF_WAIT.
  - RF_WAIT:
    - Waits for rf_done; on rf_done -> IDLE with pending decremented.
    - rf_done seen in any other state is ignored and does not decrement.
- Latency:
  - host_req rising in IDLE with no urgency -> host_grant=1 one cycle later.
  - Refresh back-to-back: RF_WAIT -> IDLE -> RF_ISSUE, minimum 2 cycles between rf_done and the next rf_start.
- There is a minimum 1-cycle IDLE between any two ownerships; host_grant and rf_start are never both 1.
- Async reset mid-operation: all state cleared immediately. The refresh engine is expected to be reset by the same rst_n.

Test Plan:
- rf_en=1, array_tREFI=100, host_req=0, engine returns rf_done 10 cycles after rf_start:
  - first rf_start 101-102 cycles after rf_en rises, then every 100 cycles.
  - rf_pending toggles 0->1->0; rf_overflow stays 0.
- Host postpone: tREFI=20, host_req held high for 70 cycles starting in IDLE:
  - host_grant high throughout.
  - rf_pending reaches 3, no rf_start.
  - After host_req drops: three refreshes back-to-back, pending 3->0.
- Urgency: MAX_POSTPONE=4, tREFI=20, host holds for 90 cycles:
  - pending hits 4 and rf_urgent=1.
  - After host release, a new host_req raised in the same cycle as IDLE is ignored until pending<4.
  - rf_start occurs first.
- Overflow: keep host granted for 120 cycles with tREFI=20:
  - pending saturates at 4 and rf_overflow=1 at the 5th tick.
  - rf_overflow remains 1 after draining.
- Simultaneous tick and rf_done: align the tick with rf_done in RF_WAIT with pending=1:
  - pending stays 1 and the next rf_start follows 2 cycles later.
  - A spurious rf_done in IDLE leaves pending unchanged.
- Reset mid-refresh: assert rst_n low during RF_WAIT with pending=2:
  - all outputs are 0 immediately.
  - After release, the first rf_start comes tREFI cycles later.
